systolic_pe_fxp: RTL and testbench

//  Parametrised output-stationary systolic PE, successor to the single fixed-point PE. Forwards operands

---
 rtl/pe_pkg.sv | 48 ++++
 rtl/pe_fxp_mul_round.sv | 63 ++++++
 rtl/systolic_pe_fxp.sv | 143 ++++++++++++++
 tb/tb_systolic_pe_fxp.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the fixed-point processing elements: rounding modes,
// accumulator FSM states and wide saturation helpers.
package pe_pkg;

  // Internal arithmetic width; all intermediates are widened to this before clamping.
  localparam int unsigned SAT_W = 128;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_unsigned(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    hi = (SAT_W'(1) << w) - SAT_W'(1);
    if (v < 0)       return '0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w,
    input logic                    sgn
  );
    return sgn ? sat_signed(v, w) : sat_unsigned(v, w);
  endfunction

endpackage

// File: rtl/pe_fxp_mul_round.sv
// Multiply stage: full-precision product, optional half-up rounding, right shift
// by FRAC_BITS and clamp to the accumulator width, then one register stage.
module pe_fxp_mul_round
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 1,
  parameter int ROUND      = ROUND_HALF_UP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  valid_o,
  output logic                  last_o,
  output logic                  sat_o,
  output logic [ACC_WIDTH-1:0]  x_o
);

  localparam logic SGN = (SIGNED != 0);
  localparam int   RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [SAT_W-1:0] RND_ADD =
    (ROUND == ROUND_HALF_UP && FRAC_BITS > 0) ? (SAT_W'(1) << RND_SH) : '0;

  logic signed [SAT_W-1:0] a_ext, b_ext, prod, rnd, shf, clamped;
  logic [ACC_WIDTH-1:0]    x_d, x_q;
  logic                    sat_d, sat_q, valid_q, last_q;

  always_comb begin
    a_ext   = {{(SAT_W-DATA_WIDTH){SGN ? a_i[DATA_WIDTH-1] : 1'b0}}, a_i};
    b_ext   = {{(SAT_W-DATA_WIDTH){SGN ? b_i[DATA_WIDTH-1] : 1'b0}}, b_i};
    prod    = a_ext * b_ext;
    rnd     = prod + RND_ADD;
    shf     = rnd >>> FRAC_BITS;
    clamped = saturate(shf, ACC_WIDTH, SGN);
    x_d     = ACC_WIDTH'(clamped);
    sat_d   = (clamped != shf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
      x_q     <= '0;
    end else begin
      valid_q <= valid_i;
      last_q  <= valid_i & last_i;
      sat_q   <= sat_d;
      x_q     <= x_d;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign sat_o   = sat_q;
  assign x_o     = x_q;

endmodule

// File: rtl/systolic_pe_fxp.sv
// Output-stationary systolic PE: forwards operands down/right and accumulates
// rounded fixed-point products with saturation, strobing each finished dot product.
module systolic_pe_fxp
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int SIGNED     = 1,
  parameter int ROUND      = ROUND_HALF_UP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_last,
  input  logic [DATA_WIDTH-1:0] i_up,
  input  logic [DATA_WIDTH-1:0] i_left,
  output logic [DATA_WIDTH-1:0] o_down,
  output logic [DATA_WIDTH-1:0] o_right,
  output logic                  o_valid,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_result_valid,
  output logic                  o_sat
);

  localparam logic SGN = (SIGNED != 0);

  logic [DATA_WIDTH-1:0] down_q, right_q;
  logic                  fwd_valid_q, fwd_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_q      <= '0;
      right_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_last_q  <= 1'b0;
    end else begin
      down_q      <= i_up;
      right_q     <= i_left;
      fwd_valid_q <= i_valid;
      fwd_last_q  <= i_last;
    end
  end

  logic                 p_valid, p_last, p_sat;
  logic [ACC_WIDTH-1:0] p_x;

  pe_fxp_mul_round #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_WIDTH  (ACC_WIDTH),
    .SIGNED     (SIGNED),
    .ROUND      (ROUND)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .valid_i (i_valid),
    .last_i  (i_last),
    .a_i     (i_up),
    .b_i     (i_left),
    .valid_o (p_valid),
    .last_o  (p_last),
    .sat_o   (p_sat),
    .x_o     (p_x)
  );

  acc_state_e            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  stk_q, stk_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  res_sat_q, res_sat_d;
  logic                  res_vld_q, res_vld_d;

  logic signed [SAT_W-1:0] acc_ext, x_ext, sum, sum_sat, acc_next, res_wide;
  logic                    add_ovf, dw_ovf, stk_next;

  // acc_next/stk_next are the post-term values; the final strobe uses them
  // directly so the last product is included in the reported result.
  always_comb begin
    acc_ext  = {{(SAT_W-ACC_WIDTH){SGN ? acc_q[ACC_WIDTH-1] : 1'b0}}, acc_q};
    x_ext    = {{(SAT_W-ACC_WIDTH){SGN ? p_x[ACC_WIDTH-1] : 1'b0}}, p_x};
    sum      = acc_ext + x_ext;
    sum_sat  = saturate(sum, ACC_WIDTH, SGN);
    add_ovf  = (sum_sat != sum);
    if (state_q == ST_IDLE) begin
      acc_next = x_ext;
      stk_next = p_sat;
    end else begin
      acc_next = sum_sat;
      stk_next = stk_q | p_sat | add_ovf;
    end
    res_wide = saturate(acc_next, DATA_WIDTH, SGN);
    dw_ovf   = (res_wide != acc_next);

    state_d   = state_q;
    acc_d     = acc_q;
    stk_d     = stk_q;
    res_d     = res_q;
    res_sat_d = res_sat_q;
    res_vld_d = 1'b0;
    if (p_valid) begin
      acc_d   = ACC_WIDTH'(acc_next);
      stk_d   = stk_next;
      state_d = ST_ACCUM;
      if (p_last) begin
        res_d     = DATA_WIDTH'(res_wide);
        res_sat_d = stk_next | dw_ovf;
        res_vld_d = 1'b1;
        acc_d     = '0;
        stk_d     = 1'b0;
        state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      stk_q     <= 1'b0;
      res_q     <= '0;
      res_sat_q <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      stk_q     <= stk_d;
      res_q     <= res_d;
      res_sat_q <= res_sat_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign o_down         = down_q;
  assign o_right        = right_q;
  assign o_valid        = fwd_valid_q;
  assign o_last         = fwd_last_q;
  assign o_result       = res_q;
  assign o_result_valid = res_vld_q;
  assign o_sat          = res_sat_q;

endmodule

// File: tb/tb_systolic_pe_fxp.sv
// Scoreboard bench: two PEs (truncate and round-half-up) share stimulus; a
// reference model pushes expected dot products, a monitor pops them on each strobe.
module tb_systolic_pe_fxp;

  logic clk = 1'b0;
  logic rst;
  logic i_valid, i_last;
  logic [15:0] i_up, i_left;

  logic [15:0] dn0, rt0, res0, dn1, rt1, res1;
  logic        ov0, ol0, rv0, st0, ov1, ol1, rv1, st1;

  always #5 clk = ~clk;

  systolic_pe_fxp #(
    .DATA_WIDTH (16), .FRAC_BITS (8), .ACC_WIDTH (32), .SIGNED (1), .ROUND (0)
  ) dut_r0 (
    .clk (clk), .rst (rst), .i_valid (i_valid), .i_last (i_last),
    .i_up (i_up), .i_left (i_left), .o_down (dn0), .o_right (rt0),
    .o_valid (ov0), .o_last (ol0), .o_result (res0),
    .o_result_valid (rv0), .o_sat (st0)
  );

  systolic_pe_fxp #(
    .DATA_WIDTH (16), .FRAC_BITS (8), .ACC_WIDTH (32), .SIGNED (1), .ROUND (1)
  ) dut_r1 (
    .clk (clk), .rst (rst), .i_valid (i_valid), .i_last (i_last),
    .i_up (i_up), .i_left (i_left), .o_down (dn1), .o_right (rt1),
    .o_valid (ov1), .o_last (ol1), .o_result (res1),
    .o_result_valid (rv1), .o_sat (st1)
  );

  typedef struct {
    logic [15:0] r;
    logic        s;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  int     checks = 0;
  int     errors = 0;
  longint macc[2];
  logic   msat[2];
  bit     mbusy;

  function automatic longint clampw(input longint v, input int w);
    longint hi;
    hi = (longint'(1) << (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic longint term(input int a, input int b, input int r);
    longint p;
    p = longint'(a) * longint'(b);
    if (r == 1) p = p + 128;
    return p >>> 8;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 2; r++) begin
      macc[r] = 0;
      msat[r] = 1'b0;
    end
    mbusy = 1'b0;
  endtask

  task automatic drive(input int a, input int b, input bit l);
    longint t, tc, s, sc, res;
    exp_t   e;
    @(negedge clk);
    i_valid = 1'b1;
    i_last  = l;
    i_up    = a[15:0];
    i_left  = b[15:0];
    for (int r = 0; r < 2; r++) begin
      t  = term(a, b, r);
      tc = clampw(t, 32);
      if (!mbusy) begin
        macc[r] = tc;
        msat[r] = (tc != t);
      end else begin
        s  = macc[r] + tc;
        sc = clampw(s, 32);
        msat[r] = msat[r] | (tc != t) | (sc != s);
        macc[r] = sc;
      end
      if (l) begin
        res = clampw(macc[r], 16);
        e.r = res[15:0];
        e.s = msat[r] | (res != macc[r]);
        if (r == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
    mbusy = 1'b1;
    if (l) model_clear();
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rv0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL r0_unexpected_strobe got=%h expected no strobe", res0);
      end else begin
        e = q0.pop_front();
        if (res0 !== e.r || st0 !== e.s) begin
          errors++;
          $display("FAIL r0_result got=%h sat=%b expected=%h sat=%b", res0, st0, e.r, e.s);
        end
      end
    end
    if (rv1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL r1_unexpected_strobe got=%h expected no strobe", res1);
      end else begin
        e = q1.pop_front();
        if (res1 !== e.r || st1 !== e.s) begin
          errors++;
          $display("FAIL r1_result got=%h sat=%b expected=%h sat=%b", res1, st1, e.r, e.s);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_up = '0; i_left = '0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if ({res0, rv0, st0, dn0, rt0, ov0, ol0} !== '0) begin
      errors++;
      $display("FAIL reset_r0 got=%h expected=0", {res0, rv0, st0, dn0, rt0, ov0, ol0});
    end
    checks++;
    if ({res1, rv1, st1, dn1, rt1, ov1, ol1} !== '0) begin
      errors++;
      $display("FAIL reset_r1 got=%h expected=0", {res1, rv1, st1, dn1, rt1, ov1, ol1});
    end
    rst = 1'b0;
  endtask

  task automatic test_trunc_latency();
    drive(100, 20, 1'b0);
    drive(100, 40, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (rv0 !== 1'b0) begin
      errors++; $display("FAIL latency_early got=%b expected=0", rv0);
    end
    idle();
    @(posedge clk); #1;
    checks++;
    if (rv0 !== 1'b1 || res0 !== 16'd22 || st0 !== 1'b0) begin
      errors++;
      $display("FAIL trunc_sum got=%b/%0d/%b expected=1/22/0", rv0, res0, st0);
    end
    @(posedge clk); #1;
    checks++;
    if (rv0 !== 1'b0 || res0 !== 16'd22) begin
      errors++; $display("FAIL result_hold got=%b/%0d expected=0/22", rv0, res0);
    end
  endtask

  task automatic test_rounding();
    drive(100, 20, 1'b0);
    drive(100, 20, 1'b0);
    drive(100, 40, 1'b1);
    idle();
    @(posedge clk); #1;
    checks++;
    if (res1 !== 16'd32 || res0 !== 16'd29) begin
      errors++; $display("FAIL round_sum got=%0d/%0d expected=32/29", res1, res0);
    end
  endtask

  task automatic test_signed();
    drive(-256, 256, 1'b1);
    idle();
    @(posedge clk); #1;
    checks++;
    if (res1 !== 16'hFF00) begin
      errors++; $display("FAIL signed_neg got=%h expected=ff00", res1);
    end
    drive(-384, 1, 1'b1);
    idle();
    @(posedge clk); #1;
    checks++;
    if (res1 !== 16'hFFFF || res0 !== 16'hFFFE) begin
      errors++; $display("FAIL signed_round got=%h/%h expected=ffff/fffe", res1, res0);
    end
  endtask

  task automatic test_saturation();
    drive(32767, 32767, 1'b1);
    idle();
    @(posedge clk); #1;
    checks++;
    if (res1 !== 16'h7FFF || st1 !== 1'b1) begin
      errors++; $display("FAIL sat_pos got=%h/%b expected=7fff/1", res1, st1);
    end
    drive(1, 256, 1'b1);
    drive(-32768, 32767, 1'b1);
    idle();
    idle();
    checks++;
    if (res1 !== 16'h8000 || st1 !== 1'b1) begin
      errors++; $display("FAIL sat_neg got=%h/%b expected=8000/1", res1, st1);
    end
  endtask

  task automatic test_back_to_back();
    drive(100, 20, 1'b0);
    idle();
    idle();
    drive(100, 40, 1'b1);
    drive(50, 60, 1'b1);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ol1 !== 1'b1 || ov1 !== 1'b0) begin
      errors++; $display("FAIL last_no_valid_fwd got=%b/%b expected=1/0", ol1, ov1);
    end
    idle();
    idle();
  endtask

  task automatic test_reset_mid_sum();
    drive(300, 300, 1'b0);
    drive(200, 100, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    i_valid = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rv1 !== 1'b0 || res1 !== 16'd0 || st1 !== 1'b0) begin
      errors++; $display("FAIL reset_mid got=%b/%0d/%b expected=0/0/0", rv1, res1, st1);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(512, 256, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (dn1 !== 16'd512 || rt1 !== 16'd256 || ov1 !== 1'b1 || ol1 !== 1'b1) begin
      errors++;
      $display("FAIL forward got=%0d/%0d/%b/%b expected=512/256/1/1", dn1, rt1, ov1, ol1);
    end
    idle();
    @(posedge clk); #1;
    checks++;
    if (res1 !== 16'd512 || res0 !== 16'd512) begin
      errors++; $display("FAIL post_reset_sum got=%0d/%0d expected=512/512", res1, res0);
    end
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 20; k++) begin
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) begin
        drive(int'($urandom_range(0, 8000)) - 4000, int'($urandom_range(0, 8000)) - 4000, j == n - 1);
        if ($urandom_range(0, 3) == 0) idle();
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_trunc_latency();
    test_rounding();
    test_signed();
    test_saturation();
    test_back_to_back();
    test_reset_mid_sum();
    test_random();
    repeat (6) idle();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d/%0d pending expected=0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
